// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared sizing, saturation limits and FSM state for the signed fixed-point divider.
package fixed_point_pkg;
  localparam int FP_WIDTH = 16;
  localparam int FP_FRAC = 7;
  localparam int ITERS = FP_WIDTH + FP_FRAC + 1;
  localparam logic [FP_WIDTH-1:0] Q_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
  localparam logic [FP_WIDTH-1:0] Q_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
endpackage

// File: rtl/fixed_point_div_if.sv
// fixed_point_div_if: request/result bundle between a divider client (master) and the divider (slave).
interface fixed_point_div_if
  import fixed_point_pkg::*;
#(parameter int WIDTH = FP_WIDTH);
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic overflow_flag;
  logic div_by_zero;
  modport master(output start, dividend, divisor, input busy, done, result, overflow_flag, div_by_zero);
  modport slave(input start, dividend, divisor, output busy, done, result, overflow_flag, div_by_zero);
endinterface

// File: rtl/fixed_point_div.sv
// fixed_point_div: signed fixed-point divider, restoring radix-2, one quotient bit per cycle, rounded and saturated.
module fixed_point_div
  import fixed_point_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int FRAC = FP_FRAC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             div_by_zero
);
  localparam int NUM_W = WIDTH + FRAC + 1;
  localparam int CNT_W = $clog2(NUM_W + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] num_q, num_d, mag;
  logic [WIDTH:0] den_q, den_d, trial;
  logic [WIDTH-1:0] rem_q, rem_d, res_q, res_d, dvd_abs, dvs_abs, mag_neg;
  logic sign_q, sign_d, dvd_neg_q, dvd_neg_d;
  logic done_q, done_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic q_bit, ovf, dbz;
  always_comb begin
    dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_abs = divisor[WIDTH-1] ? -divisor : divisor;
    // num_q shifts the numerator out MSB-first while quotient bits shift in at the LSB
    trial = {rem_q, num_q[NUM_W-1]};
    q_bit = trial >= den_q;
    mag = (num_q >> 1) + NUM_W'(num_q[0]);
    mag_neg = -mag[WIDTH-1:0];
    ovf = sign_q ? (mag > NUM_W'(Q_MIN)) : (mag > NUM_W'(Q_MAX));
    dbz = den_q == '0;
    state_d = state_q;
    cnt_d = cnt_q;
    num_d = num_q;
    den_d = den_q;
    rem_d = rem_q;
    sign_d = sign_q;
    dvd_neg_d = dvd_neg_q;
    res_d = res_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = CALC;
      cnt_d = '0;
      num_d = {dvd_abs, {(FRAC+1){1'b0}}};
      den_d = {1'b0, dvs_abs};
      rem_d = '0;
      sign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      dvd_neg_d = dividend[WIDTH-1];
    end
    if (state_q == CALC) begin
      if (cnt_q == CNT_W'(ITERS)) state_d = FINISH;
      else begin
        cnt_d = cnt_q + CNT_W'(1);
        rem_d = q_bit ? WIDTH'(trial - den_q) : trial[WIDTH-1:0];
        num_d = {num_q[NUM_W-2:0], q_bit};
      end
    end
    if (state_q == FINISH) begin
      state_d = IDLE;
      done_d = 1'b1;
      dbz_d = dbz;
      ovf_d = !dbz && ovf;
      res_d = dbz ? (dvd_neg_q ? Q_MIN : Q_MAX) :
              ovf ? (sign_q ? Q_MIN : Q_MAX) :
              sign_q ? mag_neg : mag[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      num_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      sign_q <= 1'b0;
      dvd_neg_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      den_q <= den_d;
      rem_q <= rem_d;
      sign_q <= sign_d;
      dvd_neg_q <= dvd_neg_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      dbz_q <= dbz_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign result = res_q;
  assign overflow_flag = ovf_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_fixed_point_div.sv
// tb_fixed_point_div: directed and randomized checks of fixed_point_div against an arithmetic reference model.
module tb_fixed_point_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  fixed_point_div_if io();
  fixed_point_div dut (
    .clk(clk), .rst(rst), .start(io.start), .dividend(io.dividend), .divisor(io.divisor),
    .busy(io.busy), .done(io.done), .result(io.result),
    .overflow_flag(io.overflow_flag), .div_by_zero(io.div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic o, output logic z);
    longint na, nb, q, m;
    logic s;
    na = longint'($signed(a));
    nb = longint'($signed(b));
    s = a[15] ^ b[15];
    z = b == 16'h0;
    o = 1'b0;
    if (z) r = a[15] ? 16'h8000 : 16'h7FFF;
    else begin
      q = ((na < 0 ? -na : na) * 256) / (nb < 0 ? -nb : nb);
      m = (q + 1) / 2;
      o = s ? m > 32768 : m > 32767;
      r = o ? (s ? 16'h8000 : 16'h7FFF) : 16'(s ? -m : m);
    end
  endfunction
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    io.start = 1'b1;
    io.dividend = a;
    io.divisor = b;
    @(posedge clk);
    #1 io.start = 1'b0;
    chk({tag, "_busy"}, int'(io.busy), 1);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!io.done && lat < 40);
    chk({tag, "_latency"}, lat, 26);
    chk({tag, "_result"}, int'(io.result), int'(er));
    chk({tag, "_ovf"}, int'(io.overflow_flag), int'(eo));
    chk({tag, "_dbz"}, int'(io.div_by_zero), int'(ez));
    @(posedge clk);
    #1 chk({tag, "_pulse"}, int'(io.done), 0);
    chk({tag, "_hold"}, int'(io.result), int'(er));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] a, b, er;
    logic eo, ez;
    int dq[$];
    int rq[$];
    int nd;
    io.start = 1'b0;
    io.dividend = '0;
    io.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(io.busy), 0);
    chk("rst_done", int'(io.done), 0);
    chk("rst_result", int'(io.result), 0);
    chk("rst_flags", int'({io.overflow_flag, io.div_by_zero}), 0);
    @(negedge clk) rst = 1'b0;
    run_op("d1p5", 16'h00C0, 16'h0040, 16'h0180, 1'b0, 1'b0);
    run_op("dneg", 16'hFF80, 16'h0180, 16'hFFD5, 1'b0, 1'b0);
    run_op("ovfp", 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    run_op("ovfn", 16'h8000, 16'hFF80, 16'h7FFF, 1'b1, 1'b0);
    run_op("qmin", 16'h8000, 16'h0080, 16'h8000, 1'b0, 1'b0);
    run_op("dz_n", 16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1);
    run_op("dz_p", 16'h0040, 16'h0000, 16'h7FFF, 1'b0, 1'b1);
    run_op("zero", 16'h0000, 16'hFF80, 16'h0000, 1'b0, 1'b0);
    run_op("tiny", 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    // abort an operation with reset at edge 10 after acceptance
    @(negedge clk);
    io.start = 1'b1;
    io.dividend = 16'h7FFF;
    io.divisor = 16'h0003;
    @(posedge clk);
    #1 io.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(io.busy), 0);
    chk("abort_result", int'(io.result), 0);
    chk("abort_flags", int'({io.done, io.overflow_flag, io.div_by_zero}), 0);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (30) begin
      @(posedge clk);
      #1 nd += int'(io.done);
    end
    chk("abort_no_done", nd, 0);
    run_op("after_abort", 16'hFF80, 16'h0180, 16'hFFD5, 1'b0, 1'b0);
    // reset wins over a coincident start
    @(negedge clk);
    rst = 1'b1;
    io.start = 1'b1;
    @(posedge clk);
    #1 chk("rst_prio_busy", int'(io.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    io.start = 1'b0;
    @(posedge clk);
    #1 chk("rst_prio_idle", int'(io.busy), 0);
    // start held high: operands changed mid-operation must only affect the next acceptance
    @(negedge clk);
    io.start = 1'b1;
    io.dividend = 16'h00C0;
    io.divisor = 16'h0040;
    @(posedge clk);
    #1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (io.done) begin
        dq.push_back(e);
        rq.push_back(int'(io.result));
      end
      if (e == 5) begin
        io.dividend = 16'hFF80;
        io.divisor = 16'h0180;
      end
      if (e == 53) io.start = 1'b0;
    end
    chk("b2b_count", dq.size(), 2);
    while (dq.size() < 2) begin
      dq.push_back(-1);
      rq.push_back(-1);
    end
    chk("b2b_first_edge", dq[0], 26);
    chk("b2b_second_edge", dq[1], 53);
    chk("b2b_first_result", rq[0], 32'h0180);
    chk("b2b_second_result", rq[1], 32'hFFD5);
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = $urandom_range(0, 3) == 0 ? 16'($urandom_range(1, 255)) : 16'($urandom);
      if ($urandom_range(0, 1) == 0 && b[15] == 1'b0) b = -b;
      if ($urandom_range(0, 11) == 0) b = 16'h0000;
      model(a, b, er, eo, ez);
      run_op("rand", a, b, er, eo, ez);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fixed_point_div.md
FIXED_POINT_DIV -- requirements
Module: fixed_point_div

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning total signed word width.
REQ-002 SHALL have parameter FRAC, default 7, meaning fractional bits (Q9.7 at defaults).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-006 SHALL have port dividend  input  WIDTH  signed Q9.7 numerator, captured when start is accepted.
REQ-007 SHALL have port divisor  input  WIDTH  signed Q9.7 denominator, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  WIDTH  signed Q9.7 quotient, held until next done.
REQ-011 SHALL have port overflow_flag  output  1  quotient outside Q9.7 range, held with result.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero, held with result.

Function
REQ-013 SHALL use FSM states IDLE, CALC, FINISH: IDLE->CALC on start; CALC->FINISH after 24 iterations; FINISH->IDLE unconditionally.
REQ-014 SHALL, on acceptance, latch sign = dividend[15] XOR divisor[15], numerator = |dividend| << (FRAC+1) (24 bits unsigned), and denominator = |divisor| (16 bits unsigned; |0x8000| = 32768).
REQ-015 SHALL in CALC perform one restoring radix-2 step per cycle, MSB first, using a 17-bit partial remainder, producing a 24-bit unsigned quotient Q.
REQ-016 SHALL round in FINISH as magnitude M = (Q + 1) >> 1, i.e. round half away from zero.
REQ-017 SHALL set overflow_flag when M > 32767 with sign=0, or when M > 32768 with sign=1.
REQ-018 SHALL drive result = +M or -M when there is no overflow, and saturate to 0x7FFF (sign=0) or 0x8000 (sign=1) on overflow.
REQ-019 SHALL, when divisor = 0, set div_by_zero=1 and overflow_flag=0, and drive result 0x7FFF if dividend >= 0, otherwise 0x8000, with unchanged latency.
REQ-020 SHALL have fixed latency: done is high in the cycle 26 rising edges after the edge that accepted start.
REQ-021 SHALL update result, overflow_flag and div_by_zero only on the edge that raises done.
REQ-022 SHALL ignore start while busy; a start coincident with done (FSM in IDLE) SHALL be accepted.
REQ-023 SHALL produce signed zero as 0x0000 (no negative zero).

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE and clear busy, done, result, overflow_flag and div_by_zero to 0, including mid-CALC.
REQ-025 SHALL give rst priority over start in the same cycle.
REQ-026 SHALL produce no done pulse for an operation aborted by reset.

Structure
REQ-027 SHALL take WIDTH, FRAC, iteration count (24), Q_MAX (0x7FFF), Q_MIN (0x8000) and the FSM state enum from shared package fixed_point_pkg.
REQ-028 SHALL be a single module with no sub-module; the absolute-value and negate logic SHALL be inline.

Verification
REQ-029 SHALL cover: 0x00C0 / 0x0040 (1.5/0.5) -> result 0x0180, flags 0, done at edge 26.
REQ-030 SHALL cover: 0xFF80 / 0x0180 (-1.0/3.0) -> result 0xFFD5 (-43/128), flags 0.
REQ-031 SHALL cover: 0x7FFF / 0x0001 -> overflow_flag=1, result 0x7FFF; 0x8000 / 0xFF80 -> overflow_flag=1, result 0x7FFF; 0x8000 / 0x0080 -> 0x8000, no overflow.
REQ-032 SHALL cover: 0xFF00 / 0x0000 -> div_by_zero=1, overflow_flag=0, result 0x8000, done at edge 26.
REQ-033 SHALL cover: rst asserted at edge 10 of an operation -> no done, all outputs 0; a new start at the next cycle completes normally.
REQ-034 SHALL cover: start held high continuously -> back-to-back operations accepted every 27 cycles, extra start pulses while busy ignored.
